// File: rtl/ysyx_22041461_idu.sv
// Registered RV instruction-decode stage between IFU and EXU with valid/ready on both sides.
// Traps (ebreak, illegal) are reported as flags and park the stage in a sticky HALT state.
module ysyx_22041461_idu #(
    parameter int XLEN  = 64,
    parameter int PC_W  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PC_W-1:0]  out_pc,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [4:0]       rd,
    output logic [XLEN-1:0]  imm,
    output logic [2:0]       ctrl_alu,
    output logic [2:0]       sel_alu,
    output logic [2:0]       sel_regs,
    output logic [1:0]       sel_pc,
    output logic [1:0]       ctrl_mem,
    output logic [2:0]       sel_mem_addr,
    output logic [2:0]       sel_mem_data,
    output logic             out_ebreak,
    output logic             out_illegal,
    output logic             halted,
    output logic [CNT_W-1:0] dec_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t state_r, next_state_s;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [31:0]     imm_i32_s, imm_s32_s, imm_u32_s, imm_j32_s;
    logic [XLEN-1:0] dec_imm_s;
    logic [2:0]      dec_alu_s, dec_sel_alu_s, dec_sel_regs_s, dec_mem_addr_s, dec_mem_data_s;
    logic [1:0]      dec_sel_pc_s, dec_mem_s;
    logic            dec_ebreak_s, dec_illegal_s;
    logic            accept_s, out_hs_s;

    logic             out_valid_r;
    logic [PC_W-1:0]  out_pc_r;
    logic [4:0]       rs1_r, rs2_r, rd_r;
    logic [XLEN-1:0]  imm_r;
    logic [2:0]       ctrl_alu_r, sel_alu_r, sel_regs_r, sel_mem_addr_r, sel_mem_data_r;
    logic [1:0]       sel_pc_r, ctrl_mem_r;
    logic             ebreak_r, illegal_r;
    logic [CNT_W-1:0] count_r;

    assign opcode_s  = in_inst[6:0];
    assign funct3_s  = in_inst[14:12];
    assign imm_i32_s = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s32_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_u32_s = {in_inst[31:12], 12'b0};
    assign imm_j32_s = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    assign in_ready = (state_r == ST_RUN) && (!out_valid_r || out_ready);
    assign accept_s = in_valid && in_ready && !flush;
    assign out_hs_s = out_valid_r && out_ready;

    // Instruction decode; anything not matched is illegal with all control fields cleared
    always_comb begin
        dec_imm_s      = '0;
        dec_alu_s      = 3'b000;
        dec_sel_alu_s  = 3'b000;
        dec_sel_regs_s = 3'b000;
        dec_sel_pc_s   = 2'b00;
        dec_mem_s      = 2'b00;
        dec_mem_addr_s = 3'b000;
        dec_mem_data_s = 3'b000;
        dec_ebreak_s   = 1'b0;
        dec_illegal_s  = 1'b0;
        case (opcode_s)
            7'b0010011: begin
                if (funct3_s == 3'b000) begin
                    dec_imm_s      = XLEN'($signed(imm_i32_s));
                    dec_alu_s      = 3'b001;
                    dec_sel_alu_s  = 3'b001;
                    dec_sel_regs_s = 3'b001;
                end else if ((funct3_s == 3'b001) && (in_inst[31:26] == 6'b000000) &&
                             ((XLEN == 64) || !in_inst[25])) begin
                    dec_imm_s      = XLEN'($signed(imm_i32_s));
                    dec_alu_s      = 3'b011;
                    dec_sel_alu_s  = 3'b001;
                    dec_sel_regs_s = 3'b001;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            7'b1100111: begin
                if (funct3_s == 3'b000) begin
                    dec_imm_s      = XLEN'($signed(imm_i32_s));
                    dec_alu_s      = 3'b010;
                    dec_sel_alu_s  = 3'b001;
                    dec_sel_regs_s = 3'b011;
                    dec_sel_pc_s   = 2'b01;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            7'b0100011: begin
                // sd only exists on a 64-bit datapath
                if ((funct3_s == 3'b011) && (XLEN == 64)) begin
                    dec_imm_s      = XLEN'($signed(imm_s32_s));
                    dec_alu_s      = 3'b001;
                    dec_sel_alu_s  = 3'b001;
                    dec_mem_s      = 2'b10;
                    dec_mem_data_s = 3'b010;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            7'b0010111: begin
                dec_imm_s      = XLEN'($signed(imm_u32_s));
                dec_alu_s      = 3'b001;
                dec_sel_alu_s  = 3'b100;
                dec_sel_regs_s = 3'b001;
            end
            7'b0110111: begin
                dec_imm_s      = XLEN'($signed(imm_u32_s));
                dec_sel_regs_s = 3'b100;
            end
            7'b1101111: begin
                dec_imm_s      = XLEN'($signed(imm_j32_s));
                dec_alu_s      = 3'b001;
                dec_sel_alu_s  = 3'b100;
                dec_sel_regs_s = 3'b011;
                dec_sel_pc_s   = 2'b01;
            end
            7'b1110011: begin
                if (in_inst == 32'h0010_0073) begin
                    dec_ebreak_s = 1'b1;
                end else begin
                    dec_illegal_s = 1'b1;
                end
            end
            default: begin
                dec_illegal_s = 1'b1;
            end
        endcase
    end

    // HALT is entered on accepting a trap bundle and only reset leaves it
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (accept_s && (dec_ebreak_s || dec_illegal_s)) begin
                    next_state_s = ST_HALT;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_HALT: next_state_s = ST_HALT;
            default: next_state_s = ST_HALT;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Output valid and retired-bundle counter; flush wins over both accept and retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            count_r     <= '0;
        end else if (flush) begin
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                out_valid_r <= 1'b1;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
            end
            if (out_hs_s) begin
                count_r <= count_r + CNT_W'(1);
            end
        end
    end

    // Bundle registers load only on accept, so a stalled bundle stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_pc_r       <= '0;
            rs1_r          <= 5'd0;
            rs2_r          <= 5'd0;
            rd_r           <= 5'd0;
            imm_r          <= '0;
            ctrl_alu_r     <= 3'b000;
            sel_alu_r      <= 3'b000;
            sel_regs_r     <= 3'b000;
            sel_pc_r       <= 2'b00;
            ctrl_mem_r     <= 2'b00;
            sel_mem_addr_r <= 3'b000;
            sel_mem_data_r <= 3'b000;
            ebreak_r       <= 1'b0;
            illegal_r      <= 1'b0;
        end else if (accept_s) begin
            out_pc_r       <= in_pc;
            rs1_r          <= in_inst[19:15];
            rs2_r          <= in_inst[24:20];
            rd_r           <= in_inst[11:7];
            imm_r          <= dec_imm_s;
            ctrl_alu_r     <= dec_alu_s;
            sel_alu_r      <= dec_sel_alu_s;
            sel_regs_r     <= dec_sel_regs_s;
            sel_pc_r       <= dec_sel_pc_s;
            ctrl_mem_r     <= dec_mem_s;
            sel_mem_addr_r <= dec_mem_addr_s;
            sel_mem_data_r <= dec_mem_data_s;
            ebreak_r       <= dec_ebreak_s;
            illegal_r      <= dec_illegal_s;
        end
    end

    assign out_valid    = out_valid_r;
    assign out_pc       = out_pc_r;
    assign rs1          = rs1_r;
    assign rs2          = rs2_r;
    assign rd           = rd_r;
    assign imm          = imm_r;
    assign ctrl_alu     = ctrl_alu_r;
    assign sel_alu      = sel_alu_r;
    assign sel_regs     = sel_regs_r;
    assign sel_pc       = sel_pc_r;
    assign ctrl_mem     = ctrl_mem_r;
    assign sel_mem_addr = sel_mem_addr_r;
    assign sel_mem_data = sel_mem_data_r;
    assign out_ebreak   = ebreak_r;
    assign out_illegal  = illegal_r;
    assign halted       = (state_r == ST_HALT);
    assign dec_count    = count_r;

endmodule

// File: tb/tb_ysyx_22041461_idu.sv
// Directed bench for ysyx_22041461_idu: a 64-bit instance and a 32-bit instance (2-bit counter)
// share all inputs; a vector table covers decode, hand sequences cover handshake corners.
module tb_ysyx_22041461_idu;

    logic        clk, rst_n, in_valid, flush, out_ready;
    logic [31:0] in_inst;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_ebreak, a_illegal, a_halted;
    logic [63:0] a_out_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_alu, a_sel_alu, a_sel_regs, a_maddr, a_mdata;
    logic [1:0]  a_sel_pc, a_mem;
    logic [31:0] a_count;

    logic        b_in_ready, b_out_valid, b_ebreak, b_illegal, b_halted;
    logic [63:0] b_out_pc;
    logic [31:0] b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_alu, b_sel_alu, b_sel_regs, b_maddr, b_mdata;
    logic [1:0]  b_sel_pc, b_mem;
    logic [1:0]  b_count;

    ysyx_22041461_idu #(.XLEN(64), .PC_W(64), .CNT_W(32)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
        .out_ready(out_ready), .out_pc(a_out_pc), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
        .imm(a_imm), .ctrl_alu(a_alu), .sel_alu(a_sel_alu), .sel_regs(a_sel_regs),
        .sel_pc(a_sel_pc), .ctrl_mem(a_mem), .sel_mem_addr(a_maddr), .sel_mem_data(a_mdata),
        .out_ebreak(a_ebreak), .out_illegal(a_illegal), .halted(a_halted), .dec_count(a_count)
    );

    ysyx_22041461_idu #(.XLEN(32), .PC_W(64), .CNT_W(2)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
        .out_ready(out_ready), .out_pc(b_out_pc), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
        .imm(b_imm), .ctrl_alu(b_alu), .sel_alu(b_sel_alu), .sel_regs(b_sel_regs),
        .sel_pc(b_sel_pc), .ctrl_mem(b_mem), .sel_mem_addr(b_maddr), .sel_mem_data(b_mdata),
        .out_ebreak(b_ebreak), .out_illegal(b_illegal), .halted(b_halted), .dec_count(b_count)
    );

    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [18:0] ctrl;   // {alu, sel_alu, sel_regs, sel_pc, mem, mem_addr, mem_data}
        logic        ebreak;
        logic        illegal;
        logic        illegal32;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    localparam logic [18:0] C_ADDI  = {3'b001, 3'b001, 3'b001, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] C_JAL   = {3'b001, 3'b100, 3'b011, 2'b01, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] C_JALR  = {3'b010, 3'b001, 3'b011, 2'b01, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] C_LUI   = {3'b000, 3'b000, 3'b100, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] C_AUIPC = {3'b001, 3'b100, 3'b001, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] C_SD    = {3'b001, 3'b001, 3'b000, 2'b00, 2'b10, 3'b000, 3'b010};
    localparam logic [18:0] C_SLLI  = {3'b011, 3'b001, 3'b001, 2'b00, 2'b00, 3'b000, 3'b000};
    localparam logic [18:0] C_NONE  = 19'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] inst, input logic [63:0] imm, input logic [18:0] ctrl,
                       input logic eb, input logic il, input logic il32);
        vec_t v;
        v.inst = inst; v.imm = imm; v.ctrl = ctrl;
        v.ebreak = eb; v.illegal = il; v.illegal32 = il32;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_inst = 32'd0; in_pc = 64'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    initial begin
        add(32'h00500093, 64'd5,                  C_ADDI,  1'b0, 1'b0, 1'b0); // addi x1,x0,5
        add(32'hff010113, 64'hFFFFFFFFFFFFFFF0,   C_ADDI,  1'b0, 1'b0, 1'b0); // addi x2,x2,-16
        add(32'h008000ef, 64'd8,                  C_JAL,   1'b0, 1'b0, 1'b0); // jal x1,8
        add(32'hffdff06f, 64'hFFFFFFFFFFFFFFFC,   C_JAL,   1'b0, 1'b0, 1'b0); // jal x0,-4
        add(32'h00008067, 64'd0,                  C_JALR,  1'b0, 1'b0, 1'b0); // jalr x0,0(x1)
        add(32'h123450b7, 64'h0000000012345000,   C_LUI,   1'b0, 1'b0, 1'b0); // lui x1,0x12345
        add(32'hfffff297, 64'hFFFFFFFFFFFFF000,   C_AUIPC, 1'b0, 1'b0, 1'b0); // auipc x5,0xfffff
        add(32'h0020b423, 64'd8,                  C_SD,    1'b0, 1'b0, 1'b1); // sd x2,8(x1)
        add(32'h00309093, 64'd3,                  C_SLLI,  1'b0, 1'b0, 1'b0); // slli x1,x1,3
        add(32'h02109093, 64'd33,                 C_SLLI,  1'b0, 1'b0, 1'b1); // slli x1,x1,33
        add(32'h00100073, 64'd0,                  C_NONE,  1'b1, 1'b0, 1'b0); // ebreak
        add(32'h00000000, 64'd0,                  C_NONE,  1'b0, 1'b1, 1'b1);
        add(32'h00000073, 64'd0,                  C_NONE,  1'b0, 1'b1, 1'b1); // ecall
        add(32'h40109093, 64'd0,                  C_NONE,  1'b0, 1'b1, 1'b1); // bad funct6
        add(32'h00009067, 64'd0,                  C_NONE,  1'b0, 1'b1, 1'b1); // jalr f3=1

        // reset state
        do_reset();
        chk("rst out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst halted", {63'd0, a_halted}, 64'd0);
        chk("rst dec_count", {32'd0, a_count}, 64'd0);
        chk("rst imm", a_imm, 64'd0);
        chk("rst in_ready", {63'd0, a_in_ready}, 64'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            do_reset();
            in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = 64'h8000_0000 + 64'(i * 4);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d out_valid", i), {63'd0, a_out_valid}, 64'd1);
            chk($sformatf("v%0d out_pc", i), a_out_pc, 64'h8000_0000 + 64'(i * 4));
            chk($sformatf("v%0d regs", i), {49'd0, a_rs1, a_rs2, a_rd},
                {49'd0, vecs[i].inst[19:15], vecs[i].inst[24:20], vecs[i].inst[11:7]});
            chk($sformatf("v%0d ctrl", i),
                {45'd0, a_alu, a_sel_alu, a_sel_regs, a_sel_pc, a_mem, a_maddr, a_mdata},
                {45'd0, vecs[i].ctrl});
            chk($sformatf("v%0d traps", i), {62'd0, a_ebreak, a_illegal},
                {62'd0, vecs[i].ebreak, vecs[i].illegal});
            chk($sformatf("v%0d halted", i), {63'd0, a_halted},
                {63'd0, vecs[i].ebreak | vecs[i].illegal});
            if (!vecs[i].ebreak && !vecs[i].illegal)
                chk($sformatf("v%0d imm", i), a_imm, vecs[i].imm);
            chk($sformatf("v%0d illegal32", i), {63'd0, b_illegal}, {63'd0, vecs[i].illegal32});
            chk($sformatf("v%0d halted32", i), {63'd0, b_halted},
                {63'd0, vecs[i].illegal32 | vecs[i].ebreak});
            if (!vecs[i].illegal32 && !vecs[i].ebreak)
                chk($sformatf("v%0d imm32", i), {32'd0, b_imm}, {32'd0, vecs[i].imm[31:0]});
        end

        // addi with out_ready high: count steps one cycle after out_valid
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 64'h8000_0000;
        tick();
        in_valid = 1'b0;
        chk("addi valid", {63'd0, a_out_valid}, 64'd1);
        chk("addi count0", {32'd0, a_count}, 64'd0);
        tick();
        chk("addi retired", {63'd0, a_out_valid}, 64'd0);
        chk("addi count1", {32'd0, a_count}, 64'd1);

        // jal then lui under a 3-cycle stall
        do_reset();
        in_valid = 1'b1; in_inst = 32'h008000ef; in_pc = 64'h100;
        tick();
        in_inst = 32'h123450b7; in_pc = 64'h104;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("stall%0d valid", c), {63'd0, a_out_valid}, 64'd1);
            chk($sformatf("stall%0d in_ready", c), {63'd0, a_in_ready}, 64'd0);
            chk($sformatf("stall%0d imm", c), a_imm, 64'd8);
            chk($sformatf("stall%0d sel_pc", c), {62'd0, a_sel_pc}, 64'd1);
            chk($sformatf("stall%0d pc", c), a_out_pc, 64'h100);
            if (c < 2) tick();
        end
        out_ready = 1'b1;
        #1;
        chk("unstall in_ready", {63'd0, a_in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("lui valid", {63'd0, a_out_valid}, 64'd1);
        chk("lui imm", a_imm, 64'h12345000);
        chk("lui pc", a_out_pc, 64'h104);
        chk("lui count", {32'd0, a_count}, 64'd1);
        tick();
        chk("lui retired", {63'd0, a_out_valid}, 64'd0);
        chk("lui count2", {32'd0, a_count}, 64'd2);

        // ebreak halts intake; count stops after it retires; flush cannot leave HALT
        do_reset();
        in_valid = 1'b1; in_inst = 32'h00100073;
        tick();
        in_inst = 32'h00500093;
        chk("ebreak flag", {63'd0, a_ebreak}, 64'd1);
        chk("ebreak halted", {63'd0, a_halted}, 64'd1);
        chk("ebreak in_ready", {63'd0, a_in_ready}, 64'd0);
        out_ready = 1'b1;
        tick();
        chk("ebreak retired", {63'd0, a_out_valid}, 64'd0);
        chk("ebreak count", {32'd0, a_count}, 64'd1);
        chk("halt in_ready", {63'd0, a_in_ready}, 64'd0);
        tick(); tick(); tick();
        chk("halt no intake", {63'd0, a_out_valid}, 64'd0);
        chk("halt count", {32'd0, a_count}, 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush keeps halt", {63'd0, a_halted}, 64'd1);

        // flush while holding a bundle with a new input offered
        do_reset();
        in_valid = 1'b1; in_inst = 32'h00500093;
        tick();
        in_inst = 32'h123450b7; flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush valid", {63'd0, a_out_valid}, 64'd0);
        chk("flush count", {32'd0, a_count}, 64'd0);
        chk("flush halted", {63'd0, a_halted}, 64'd0);
        tick();
        chk("flush nothing", {63'd0, a_out_valid}, 64'd0);

        // async reset mid-stall clears outputs before any clock edge
        do_reset();
        in_valid = 1'b1; in_inst = 32'h00500093;
        tick();
        in_valid = 1'b0;
        chk("pre-rst valid", {63'd0, a_out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst valid", {63'd0, a_out_valid}, 64'd0);
        chk("async rst imm", a_imm, 64'd0);
        chk("async rst rd", {59'd0, a_rd}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back stream of 5 and counter wrap on the 2-bit instance
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("stream valid", {63'd0, a_out_valid}, 64'd1);
        tick();
        chk("stream count", {32'd0, a_count}, 64'd5);
        chk("wrap count", {62'd0, b_count}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
